// File: rtl/div_nonrestoring_pkg.sv
// div_nonrestoring_pkg: shared multdiv widths, divider latency and FSM state encoding.
package div_nonrestoring_pkg;
   localparam int MD_WIDTH = 32;
   localparam int MD_CNT_W = 6;
   localparam int MD_DIV_LATENCY = 34;
   typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX, MD_DONE} md_state_t;
endpackage

// File: rtl/div_nonrestoring_if.sv
// div_nonrestoring_if: divider request/result bundle; data_remainder exists only with DIV_REMAINDER_EN.
interface div_nonrestoring_if #(parameter int WIDTH = 32);
   logic ctrl_DIV;
   logic [WIDTH-1:0] data_operandA, data_operandB, data_result;
   logic data_exception, data_resultRDY;
`ifdef DIV_REMAINDER_EN
   logic [WIDTH-1:0] data_remainder;
   modport master(output ctrl_DIV, data_operandA, data_operandB,
                  input data_result, data_exception, data_resultRDY, data_remainder);
   modport slave(input ctrl_DIV, data_operandA, data_operandB,
                 output data_result, data_exception, data_resultRDY, data_remainder);
`else
   modport master(output ctrl_DIV, data_operandA, data_operandB,
                  input data_result, data_exception, data_resultRDY);
   modport slave(input ctrl_DIV, data_operandA, data_operandB,
                 output data_result, data_exception, data_resultRDY);
`endif
endinterface

// File: rtl/div_nonrestoring_shl_1.sv
// div_nonrestoring_shl_1: logical left shift by 1 (LSB zero-filled) from a row of 2:1 muxes.
module div_nonrestoring_shl_1 #(parameter int W = 65) (
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] y
);
   for (genvar i = 0; i < W; i++) begin : g_mux2
      if (i == 0) begin : g_lsb
         assign y[i] = en ? 1'b0 : d[i];
      end else begin : g_bit
         assign y[i] = en ? d[i-1] : d[i];
      end
   end
endmodule

// File: rtl/div_nonrestoring.sv
// div_nonrestoring: sequential signed non-restoring divider, fixed 34-cycle latency.
// DIV_REMAINDER_EN adds the corrected, sign-adjusted remainder output.
module div_nonrestoring
   import div_nonrestoring_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = MD_CNT_W
) (
   input logic            clock,
   input logic            reset,
   div_nonrestoring_if.slave bus
);
   md_state_t state, state_n;
   logic [CNT_W-1:0] count;
   logic [WIDTH:0] a, m, sum, add_in;
   logic [WIDTH-1:0] q, abs_a, abs_b;
   logic [2*WIDTH:0] sh;
   logic sq, dz, run, fix, done, sub;
`ifdef DIV_REMAINDER_EN
   logic sa;
`endif
   always_ff @(posedge clock)
      if (reset) state <= MD_IDLE;
      else state <= state_n;
   always_comb
      state_n = bus.ctrl_DIV ? MD_RUN
              : (run && count == CNT_W'(WIDTH-1)) ? MD_FIX
              : fix ? MD_DONE
              : done ? MD_IDLE
              : state;
   always_comb begin
      run = state == MD_RUN;
      fix = state == MD_FIX;
      done = state == MD_DONE;
   end
   div_nonrestoring_shl_1 #(.W(2*WIDTH+1)) u_shl (.en(run), .d({a, q}), .y(sh));
   assign abs_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
   assign abs_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
   // One adder serves both the iterations and the FIX-cycle remainder restore.
`ifdef DIV_REMAINDER_EN
   assign add_in = fix ? a : sh[2*WIDTH:WIDTH];
`else
   assign add_in = sh[2*WIDTH:WIDTH];
`endif
   assign sub = run & ~a[WIDTH];
   assign sum = add_in + (m ^ {(WIDTH+1){sub}}) + (WIDTH+1)'(sub);
   always_ff @(posedge clock)
      if (reset) begin
         a <= '0;
         q <= '0;
         m <= '0;
         count <= '0;
         sq <= 1'b0;
         dz <= 1'b0;
`ifdef DIV_REMAINDER_EN
         sa <= 1'b0;
`endif
      end else if (bus.ctrl_DIV) begin
         a <= '0;
         q <= abs_a;
         m <= {1'b0, abs_b};
         count <= '0;
         sq <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
         dz <= bus.data_operandB == '0;
`ifdef DIV_REMAINDER_EN
         sa <= bus.data_operandA[WIDTH-1];
`endif
      end else if (run) begin
         a <= sum;
         q <= sh[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
         count <= count + 1'b1;
      end
`ifdef DIV_REMAINDER_EN
      else if (fix && a[WIDTH]) a <= sum;
`endif
   // Result registers load in DONE, so an old op still reports even if a new start coincides.
   always_ff @(posedge clock)
      if (reset) begin
         bus.data_result <= '0;
         bus.data_exception <= 1'b0;
         bus.data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
         bus.data_remainder <= '0;
`endif
      end else begin
         if (done) begin
            bus.data_result <= dz ? '0 : sq ? -q : q;
            bus.data_exception <= dz;
`ifdef DIV_REMAINDER_EN
            bus.data_remainder <= dz ? '0 : sa ? -a[WIDTH-1:0] : a[WIDTH-1:0];
`endif
         end else if (bus.ctrl_DIV) bus.data_exception <= 1'b0;
         bus.data_resultRDY <= done;
      end
endmodule

// File: tb/tb_div_nonrestoring.sv
// tb_div_nonrestoring: directed and random signed divisions against a $signed arithmetic model.
module tb_div_nonrestoring;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int fails = 0;
   int rdy_pos[$];
   logic [31:0] res_q[$], rem_q[$];
   logic exc_q[$];
   logic [31:0] res_rst;
   logic exc0;
   div_nonrestoring_if bus();
   div_nonrestoring dut (.clock(clk), .reset(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] mq(input logic [31:0] a, input logic [31:0] b);
      if (b == 0) return 32'd0;
      if (a == 32'h8000_0000 && b == 32'hffff_ffff) return a;
      return 32'($signed(a) / $signed(b));
   endfunction
   function automatic logic [31:0] mr(input logic [31:0] a, input logic [31:0] b);
      if (b == 0 || (a == 32'h8000_0000 && b == 32'hffff_ffff)) return 32'd0;
      return 32'($signed(a) % $signed(b));
   endfunction
   // Start at edge 0, optionally restart at edge k and/or reset at edge rk; log every RDY seen.
   task automatic drive(input logic [31:0] a, input logic [31:0] b, input int k,
                        input logic [31:0] a2, input logic [31:0] b2, input int rk, input int n);
      rdy_pos.delete();
      res_q.delete();
      rem_q.delete();
      exc_q.delete();
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         bus.ctrl_DIV = (i == 0) || (i == k);
         bus.data_operandA = (i == k) ? a2 : a;
         bus.data_operandB = (i == k) ? b2 : b;
         rst = (i == rk);
         @(posedge clk);
         #1;
         if (i == 0) exc0 = bus.data_exception;
         if (i == rk) res_rst = bus.data_result;
         if (bus.data_resultRDY) begin
            rdy_pos.push_back(i);
            res_q.push_back(bus.data_result);
            exc_q.push_back(bus.data_exception);
`ifdef DIV_REMAINDER_EN
            rem_q.push_back(bus.data_remainder);
`else
            rem_q.push_back(32'd0);
`endif
         end
      end
      bus.ctrl_DIV = 1'b0;
      rst = 1'b0;
   endtask
   task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b);
      drive(a, b, -1, 32'd0, 32'd0, -1, 38);
      check({tag, " n_rdy"}, 32'(rdy_pos.size()), 32'd1);
      if (rdy_pos.size() > 0) begin
         check({tag, " latency"}, 32'(rdy_pos[0]), 32'd34);
         check({tag, " result"}, res_q[0], mq(a, b));
         check({tag, " exc"}, 32'(exc_q[0]), 32'(b == 0));
`ifdef DIV_REMAINDER_EN
         check({tag, " rem"}, rem_q[0], mr(a, b));
`endif
      end
   endtask
   initial begin
      bus.ctrl_DIV = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst result", bus.data_result, 32'd0);
      check("rst exc", 32'(bus.data_exception), 32'd0);
      check("rst rdy", 32'(bus.data_resultRDY), 32'd0);
`ifdef DIV_REMAINDER_EN
      check("rst rem", bus.data_remainder, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      check_op("100/7", 32'd100, 32'd7);
      check_op("-100/7", -32'd100, 32'd7);
      check_op("100/-7", 32'd100, -32'd7);
      check_op("5/0", 32'd5, 32'd0);
      check_op("9/3", 32'd9, 32'd3);
      check("exc cleared on start", 32'(exc0), 32'd0);
      check_op("min/-1", 32'h8000_0000, 32'hffff_ffff);
      check_op("min/1", 32'h8000_0000, 32'd1);
      check_op("min/min", 32'h8000_0000, 32'h8000_0000);
      check_op("0/-5", 32'd0, -32'd5);
      drive(32'd7, 32'd2, 10, 32'd9, 32'd3, -1, 60);
      check("abort n_rdy", 32'(rdy_pos.size()), 32'd1);
      if (rdy_pos.size() > 0) begin
         check("abort latency", 32'(rdy_pos[0]), 32'd44);
         check("abort result", res_q[0], 32'd3);
      end
      drive(32'd100, 32'd7, 34, -32'd9, 32'd2, -1, 80);
      check("overlap n_rdy", 32'(rdy_pos.size()), 32'd2);
      if (rdy_pos.size() == 2) begin
         check("overlap pos0", 32'(rdy_pos[0]), 32'd34);
         check("overlap res0", res_q[0], 32'd14);
         check("overlap pos1", 32'(rdy_pos[1]), 32'd68);
         check("overlap res1", res_q[1], -32'd4);
      end
      drive(32'd100, 32'd7, -1, 32'd0, 32'd0, 20, 50);
      check("reset n_rdy", 32'(rdy_pos.size()), 32'd0);
      check("reset result", res_rst, 32'd0);
      check("reset held result", bus.data_result, 32'd0);
      check("reset exc", 32'(bus.data_exception), 32'd0);
      for (int i = 0; i < 40; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'($urandom_range(0, 15)) - 32'd8;
            1: rb = rb >> $urandom_range(0, 31);
            default: ;
         endcase
         check_op($sformatf("rand%0d %h/%h", i, ra, rb), ra, rb);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
